// File: rtl/dev_info_regs.sv
// Device-information / housekeeping register file on an Avalon-MM slave:
// identity words, 64-bit uptime with hi snapshot, scratch, sticky status and a maskable irq.
module dev_info_regs #(
    parameter int unsigned INPUT_CLOCK = 100_000_000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned NUM_STATUS  = 8,
    parameter logic [31:0] DEV_ID      = 32'h4D464441,
    parameter logic [31:0] VERSION     = 32'h0,
    parameter logic [31:0] TIMESTAMP   = 32'h0,
    parameter logic [31:0] HASH        = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     ams_address,
    input  logic                  ams_read,
    input  logic                  ams_write,
    input  logic [31:0]           ams_writedata,
    input  logic [3:0]            ams_byteenable,
    output logic [31:0]           ams_readdata,
    output logic                  ams_readdatavalid,
    input  logic [4:0]            mkio_address,
    input  logic [31:0]           crc_in,
    input  logic [NUM_STATUS-1:0] status_in,
    output logic                  irq
);

    localparam int unsigned PRESCALE = INPUT_CLOCK / TICK_HZ;
    localparam int unsigned PS_W     = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_MKIO    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CRC     = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_HASH    = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] A_LIVE    = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] A_STICKY  = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] A_MASK    = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(12);

    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q;
    logic                  irq_q;
    logic [PS_W-1:0]       prescale_q, prescale_d;
    logic [63:0]           uptime_q, uptime_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [31:0]           scratch_q, scratch_d;
    logic [NUM_STATUS-1:0] live_q;
    logic [NUM_STATUS-1:0] sticky_q, sticky_d;
    logic [NUM_STATUS-1:0] mask_q, mask_d;
    logic                  freeze_q, freeze_d;

    logic                  wr_scratch, wr_mask, wr_sticky, ctrl_wr, ctrl_clear;
    logic [NUM_STATUS-1:0] w1c_bits;
    logic [31:0]           mask_wide_q, mask_wide_d;
    logic [31:0]           read_mux;

    assign wr_scratch = ams_write && (ams_address == A_SCRATCH);
    assign wr_mask    = ams_write && (ams_address == A_MASK);
    assign wr_sticky  = ams_write && (ams_address == A_STICKY) && ams_byteenable[0];
    assign ctrl_wr    = ams_write && (ams_address == A_CTRL) && ams_byteenable[0];
    assign ctrl_clear = ctrl_wr && ams_writedata[0];

    // A CLEAR command is a pure action: the FREEZE setting survives it.
    assign freeze_d = (ctrl_wr && !ams_writedata[0]) ? ams_writedata[1] : freeze_q;

    assign mask_wide_q = 32'(mask_q);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign scratch_d[8*gi +: 8] = (wr_scratch && ams_byteenable[gi]) ?
                                          ams_writedata[8*gi +: 8] : scratch_q[8*gi +: 8];
            assign mask_wide_d[8*gi +: 8] = (wr_mask && ams_byteenable[gi]) ?
                                            ams_writedata[8*gi +: 8] : mask_wide_q[8*gi +: 8];
        end
        for (gi = 0; gi < NUM_STATUS; gi++) begin : g_w1c
            if (gi < 8) begin : g_lane0
                assign w1c_bits[gi] = wr_sticky && ams_writedata[gi];
            end else begin : g_none
                assign w1c_bits[gi] = 1'b0;
            end
        end
    endgenerate

    assign mask_d = mask_wide_d[NUM_STATUS-1:0];

    // A flag that is still live re-sets in the same edge, so it cannot be cleared.
    assign sticky_d = (sticky_q & ~w1c_bits) | live_q;

    // Snapshot the high word of the same counter value the low-word read returns.
    assign shadow_d = (ams_read && ams_address == A_UP_LO) ? uptime_q[63:32] : shadow_q;

    always_comb begin
        prescale_d = prescale_q;
        uptime_d   = uptime_q;
        if (ctrl_clear) begin
            prescale_d = '0;
            uptime_d   = '0;
        end else if (!freeze_q) begin
            if (prescale_q == PS_LAST) begin
                prescale_d = '0;
                uptime_d   = uptime_q + 64'd1;
            end else begin
                prescale_d = prescale_q + PS_W'(1);
            end
        end
    end

    always_comb begin
        read_mux = 32'h0;
        case (ams_address)
            A_ID:      read_mux = DEV_ID;
            A_MKIO:    read_mux = {27'b0, mkio_address};
            A_UP_LO:   read_mux = uptime_q[31:0];
            A_UP_HI:   read_mux = shadow_q;
            A_VERSION: read_mux = VERSION;
            A_CRC:     read_mux = crc_in;
            A_TSTAMP:  read_mux = TIMESTAMP;
            A_HASH:    read_mux = HASH;
            A_SCRATCH: read_mux = scratch_q;
            A_LIVE:    read_mux = 32'(live_q);
            A_STICKY:  read_mux = 32'(sticky_q);
            A_MASK:    read_mux = mask_wide_q;
            A_CTRL:    read_mux = {30'b0, freeze_q, 1'b0};
            default:   read_mux = 32'h0;
        endcase
    end

    assign rdata_d = ams_read ? read_mux : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
            prescale_q <= '0;
            uptime_q   <= '0;
            shadow_q   <= '0;
            scratch_q  <= '0;
            live_q     <= '0;
            sticky_q   <= '0;
            mask_q     <= '0;
            freeze_q   <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rvalid_q   <= ams_read;
            irq_q      <= |(sticky_q & mask_q);
            prescale_q <= prescale_d;
            uptime_q   <= uptime_d;
            shadow_q   <= shadow_d;
            scratch_q  <= scratch_d;
            live_q     <= status_in;
            sticky_q   <= sticky_d;
            mask_q     <= mask_d;
            freeze_q   <= freeze_d;
        end
    end

    // Gating with reset drops a read whose data phase collides with reset.
    assign ams_readdata      = rdata_q & {32{~reset}};
    assign ams_readdatavalid = rvalid_q & ~reset;
    assign irq               = irq_q;

endmodule

// File: tb/tb_dev_info_regs.sv
// Bench for dev_info_regs: directed vector table, multi-cycle corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_dev_info_regs;

    localparam logic [31:0] DEV_ID_TB = 32'h4D464441;
    localparam logic [31:0] VER_TB    = 32'h0102_0304;
    localparam logic [31:0] TS_TB     = 32'h6500_1234;
    localparam logic [31:0] HASH_TB   = 32'hDEAD_BEEF;
    localparam logic [31:0] CRC_TB    = 32'h1234_5678;
    localparam logic [4:0]  MKIO_TB   = 5'h15;
    localparam longint unsigned PRESCALE_TB = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ams_address = '0;
    logic        ams_read = 1'b0;
    logic        ams_write = 1'b0;
    logic [31:0] ams_writedata = '0;
    logic [3:0]  ams_byteenable = '0;
    logic [31:0] ams_readdata;
    logic        ams_readdatavalid;
    logic [4:0]  mkio_address = MKIO_TB;
    logic [31:0] crc_in = CRC_TB;
    logic [7:0]  status_in = '0;
    logic        irq;

    dev_info_regs #(
        .INPUT_CLOCK(10_000), .TICK_HZ(1000), .ADDR_W(4), .NUM_STATUS(8),
        .DEV_ID(DEV_ID_TB), .VERSION(VER_TB), .TIMESTAMP(TS_TB), .HASH(HASH_TB)
    ) dut (
        .clk(clk), .reset(reset),
        .ams_address(ams_address), .ams_read(ams_read), .ams_write(ams_write),
        .ams_writedata(ams_writedata), .ams_byteenable(ams_byteenable),
        .ams_readdata(ams_readdata), .ams_readdatavalid(ams_readdatavalid),
        .mkio_address(mkio_address), .crc_in(crc_in), .status_in(status_in), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] st_drv = '0;

    // Reference model: uptime is derived from the count of unfrozen cycles since clear.
    longint unsigned m_active;
    logic [31:0] m_shadow, m_scratch, m_live, m_sticky, m_mask, m_rdata;
    bit          m_freeze, m_irq, m_rv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_shadow = 0; m_scratch = 0; m_live = 0; m_sticky = 0;
        m_mask = 0; m_rdata = 0; m_freeze = 0; m_irq = 0; m_rv = 0;
    endtask

    function automatic logic [31:0] m_read(input int a);
        logic [63:0] up;
        up = 64'(m_active / PRESCALE_TB);
        case (a)
            0:  return DEV_ID_TB;
            1:  return {27'b0, MKIO_TB};
            2:  return up[31:0];
            3:  return m_shadow;
            4:  return VER_TB;
            5:  return CRC_TB;
            6:  return TS_TB;
            7:  return HASH_TB;
            8:  return m_scratch;
            9:  return m_live;
            10: return m_sticky;
            11: return m_mask;
            12: return {30'b0, m_freeze, 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                              input logic [3:0] be, input logic [7:0] st);
        logic [63:0] up;
        logic [31:0] w1c;
        bit          ctl;
        up    = 64'(m_active / PRESCALE_TB);
        m_rv  = rd;
        m_rdata = rd ? m_read(a) : 32'h0;
        if (rd && a == 2) m_shadow = up[63:32];
        m_irq = (m_sticky & m_mask) != 0;
        w1c = (wr && a == 10 && be[0]) ? {24'h0, wd[7:0]} : 32'h0;
        m_sticky = (m_sticky & ~w1c) | m_live;
        m_live = {24'h0, st};
        ctl = wr && a == 12 && be[0];
        if (ctl && wd[0]) m_active = 0;
        else if (!m_freeze) m_active += 1;
        if (ctl && !wd[0]) m_freeze = wd[1];
        for (int b = 0; b < 4; b++) begin
            if (wr && a == 8 && be[b])  m_scratch[8*b +: 8] = wd[8*b +: 8];
            if (wr && a == 11 && be[b]) m_mask[8*b +: 8] = wd[8*b +: 8];
        end
        m_mask &= 32'hFF;
    endtask

    // One bus cycle: drive at posedge+1, step the model, check just after the edge.
    task automatic cyc(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                       input logic [3:0] be);
        ams_read = rd; ams_write = wr; ams_address = 4'(a);
        ams_writedata = wd; ams_byteenable = be; status_in = st_drv;
        model_step(rd, wr, a, wd, be, st_drv);
        @(posedge clk); #1;
        chk("rvalid", 32'(ams_readdatavalid), 32'(m_rv));
        chk("rdata", ams_readdata, m_rdata);
        chk("irq", 32'(irq), 32'(m_irq));
        ams_read = 1'b0; ams_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 32'h0, 4'h0);
    endtask

    task automatic rd_exp(input int a, input logic [31:0] exp, input string nm);
        cyc(1, 0, a, 32'h0, 4'h0);
        chk(nm, ams_readdata, exp);
    endtask

    typedef struct {
        bit          do_wr;
        int          addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] exp_lo;
        vecs[0]  = '{0, 0,  32'h0,         4'h0, DEV_ID_TB,       "id"};
        vecs[1]  = '{0, 1,  32'h0,         4'h0, 32'h15,          "mkio"};
        vecs[2]  = '{0, 4,  32'h0,         4'h0, VER_TB,          "version"};
        vecs[3]  = '{0, 5,  32'h0,         4'h0, CRC_TB,          "crc"};
        vecs[4]  = '{0, 6,  32'h0,         4'h0, TS_TB,           "timestamp"};
        vecs[5]  = '{0, 7,  32'h0,         4'h0, HASH_TB,         "hash"};
        vecs[6]  = '{0, 13, 32'h0,         4'h0, 32'h0,           "unmapped13"};
        vecs[7]  = '{0, 15, 32'h0,         4'h0, 32'h0,           "unmapped15"};
        vecs[8]  = '{0, 3,  32'h0,         4'h0, 32'h0,           "shadow_init"};
        vecs[9]  = '{1, 0,  32'hFFFF_FFFF, 4'hF, DEV_ID_TB,       "ro_id_write"};
        vecs[10] = '{1, 13, 32'h1234_5678, 4'hF, 32'h0,           "unmapped_write"};
        vecs[11] = '{1, 8,  32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD,   "scratch_full"};
        vecs[12] = '{1, 8,  32'h0000_1100, 4'h2, 32'hAABB_11DD,   "scratch_byte1"};
        vecs[13] = '{1, 11, 32'hFFFF_FF08, 4'hF, 32'h0000_0008,   "mask_width"};
        vecs[14] = '{1, 12, 32'h0000_0002, 4'h0, 32'h0,           "ctrl_be0"};
        vecs[15] = '{1, 9,  32'h0000_00FF, 4'hF, 32'h0,           "ro_live_write"};

        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid", 32'(ams_readdatavalid), 32'h0);
        chk("reset_rdata", ams_readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        // 95 clocks after the reset edge the counter has ticked 9 times.
        idle(95);
        rd_exp(2, 32'd9, "uptime_95");

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].do_wr) cyc(0, 1, vecs[i].addr, vecs[i].wd, vecs[i].be);
            rd_exp(vecs[i].addr, vecs[i].exp, vecs[i].nm);
        end

        // Freeze holds the counter; CLEAR zeroes it and leaves FREEZE set.
        cyc(0, 1, 12, 32'h2, 4'hF);
        exp_lo = 32'(m_active / PRESCALE_TB);
        idle(50);
        rd_exp(2, exp_lo, "freeze_hold");
        cyc(0, 1, 12, 32'h1, 4'hF);
        rd_exp(2, 32'h0, "clear_uptime");
        rd_exp(12, 32'h2, "ctrl_after_clear");

        // Preload uptime to 0xFFFFFFFF while frozen at prescaler 0, then catch the carry.
        force dut.uptime_q = 64'h0000_0000_FFFF_FFFF;
        m_active = 64'h0000_0000_FFFF_FFFF * PRESCALE_TB;
        idle(2);
        release dut.uptime_q;
        cyc(0, 1, 12, 32'h0, 4'hF);
        idle(9);
        rd_exp(2, 32'hFFFF_FFFF, "carry_lo");
        rd_exp(3, 32'h0, "carry_shadow");
        rd_exp(2, 32'h0, "after_carry_lo");
        rd_exp(3, 32'h1, "after_carry_hi");

        // One-cycle pulse on status_in[3] with mask 0x08 already set.
        st_drv = 8'h08;
        cyc(0, 0, 0, 32'h0, 4'h0);
        st_drv = 8'h00;
        idle(1);
        chk("irq_pre", 32'(irq), 32'h0);
        idle(1);
        chk("irq_pulse", 32'(irq), 32'h1);
        rd_exp(10, 32'h08, "sticky_set");
        rd_exp(9, 32'h0, "live_after_pulse");
        cyc(0, 1, 10, 32'h08, 4'h1);
        idle(1);
        chk("irq_cleared", 32'(irq), 32'h0);
        rd_exp(10, 32'h0, "sticky_cleared");
        st_drv = 8'h08;
        idle(2);
        cyc(0, 1, 10, 32'h08, 4'h1);
        rd_exp(10, 32'h08, "w1c_while_held");
        st_drv = 8'h00;
        idle(1);
        cyc(0, 1, 10, 32'hFF, 4'h1);

        for (int i = 0; i < 600; i++) begin
            int          a;
            bit          rd, wr;
            logic [31:0] wd;
            logic [3:0]  be;
            a  = int'($urandom_range(0, 15));
            rd = ($urandom_range(0, 1) != 0);
            wr = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            if (a == 12) begin
                if ($urandom_range(0, 7) == 0) wd = 32'h1;
                else wd = ($urandom_range(0, 2) == 0) ? 32'h2 : 32'h0;
            end
            if ($urandom_range(0, 3) == 0) st_drv = 8'($urandom);
            cyc(rd, wr, a, wd, be);
        end

        // Raise irq, then collide a read's data phase with reset.
        st_drv = 8'hFF;
        cyc(0, 1, 11, 32'hFF, 4'h1);
        st_drv = 8'h00;
        idle(3);
        chk("irq_before_reset", 32'(irq), 32'h1);
        cyc(1, 0, 0, 32'h0, 4'h0);
        reset = 1'b1;
        #1;
        chk("rst_drop_rvalid", 32'(ams_readdatavalid), 32'h0);
        chk("rst_drop_rdata", ams_readdata, 32'h0);
        @(posedge clk); #1;
        chk("rst_rvalid", 32'(ams_readdatavalid), 32'h0);
        chk("rst_rdata", ams_readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        model_reset();
        idle(3);
        rd_exp(8, 32'h0, "scratch_after_reset");
        rd_exp(12, 32'h0, "ctrl_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
